fp_addsub_seq: RTL
==================

// Module: fp_addsub_seq
// PURPOSE
//  Parametrised multi-cycle IEEE-754-style floating-point add/subtract unit, successor to the combinational FPU add path.
//  Generic exponent/fraction widths, add or subtract per op, round-to-nearest-even, exception flags.
//  Uses a valid/ready handshake on both sides so it can sit between the decode/issue stage and the FP register writeback.
// PARAMETERS
//  EXP_W  8   exponent field width (bias = 2^(EXP_W-1)-1)
//  MAN_W  23  stored fraction width (hidden bit implicit); W = 1+EXP_W+MAN_W derived localparam
// PORTS
//  clk        in   1     clock, all state on rising edge
//  reset      in   1     synchronous, active-high
//  in_valid   in   1     operands/op valid
//  in_ready   out  1     unit can accept (high only in IDLE)
//  in_a       in   W     operand A {sign,exp,frac}
//  in_b       in   W     operand B
//  in_sub     in   1     0: A+B, 1: A-B (B sign inverted at accept)
//  out_valid  out  1     result valid, held until accepted
//  out_ready  in   1     consumer accepts result
//  out_result out  W     rounded result
//  out_flags  out  4     {invalid, overflow, underflow, inexact}
//  busy       out  1     state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; out_valid=0, out_result=0, out_flags=0, busy=0, in_ready=1 the cycle after reset deasserts.
//  FSM IDLE->ALIGN->ADD->NORM->ROUND->OUT->IDLE; one state per clock, no data-dependent stalls.
//  Accept on edge T where in_valid&&in_ready: operands unpacked and registered, state=ALIGN.
//  ALIGN: swap so |A|>=|B|; shift smaller significand right by exp diff into GUARD/ROUND/STICKY (sticky=OR of all bits shifted past).
//    Diff >= MAN_W+3 leaves only sticky.
//  ADD: add or subtract significands (effective op = sign_a ^ sign_b), MAN_W+4 bits plus carry.
//  NORM: carry-out -> shift right 1, exp+1 (shifted bit ORed into sticky).
//    Otherwise leading-zero count + left shift, exp-=lzc; single cycle barrel shift.
//  ROUND: RNE on guard/round/sticky; mantissa overflow after rounding -> exp+1.
//  out_valid=1 from edge T+4 (latency 4 clocks) with out_result/out_flags stable.
//  out_valid, out_result, out_flags held while out_valid && !out_ready.
//  Handshake on out_valid&&out_ready: state=IDLE, out_valid=0 next cycle; out_result/out_flags keep last value.
//  in_valid ignored when !in_ready; inputs sampled only at accept edge.
//  Specials (decided at accept, carried through pipeline, same latency):
//    NaN operand or inf-inf (eff. subtract) -> canonical NaN {0,all-ones exp,1 followed by zeros}, invalid=1
//    inf op finite -> that inf, correctly signed; flags 0
//    Denormal inputs flushed to signed zero (FTZ); zero+zero sign = AND of signs, exact x-x = +0
//  Overflow: rounded exp >= 2^EXP_W-1 -> signed inf, overflow=1, inexact=1.
//  Underflow: normalised exp <= 0 -> signed zero, underflow=1, inexact=1.
//  inexact=1 whenever guard|round|sticky nonzero before rounding.
//  Reset asserted in any state aborts: next cycle IDLE, no result emitted, in-flight operation lost.
// TESTING
//  1. 0x4048F5C3 + 0x00000000 -> 0x4048F5C3, flags 0; out_valid exactly 4 clocks after accept edge.
//  2. 0x4048F5C3 + 0x4048F5C3 -> 0x40C8F5C3, flags 0.
//  3. 0x40C8F5C3 + 0x4048F5C3 -> 0x4116B852, inexact=1.
//     Chain from (2) by feeding out_result back as in_a.
//  4. Specials:
//     0x3F800000 - 0x3F800000 -> 0x00000000
//     0x7F800000 - 0x7F800000 -> 0x7FC00000, invalid=1
//     0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow=1, inexact=1
//  5. Back-pressure: out_ready=0 for 3 clocks after out_valid -> result/flags stable, in_ready=0;
//     out_ready=1 -> out_valid drops next cycle, in_ready=1.
//  6. Reset pulsed while in NORM -> next cycle out_valid=0, in_ready=1, no result ever emitted.
//     Also rerun with EXP_W=5, MAN_W=10: 0x3C00+0x3C00 -> 0x4000.

Source files
------------

// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle floating-point add/subtract with round-to-nearest-even,
// flush-to-zero of denormal inputs, exception flags and valid/ready on both sides.
// One operation in flight; fixed 4-clock latency from accept to out_valid.
module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    input  logic                 in_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_result,
    output logic [3:0]           out_flags,
    output logic                 busy
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int SW   = MAN_W + 4;        // hidden bit + fraction + guard/round/sticky
    localparam int EW   = EXP_W + 2;        // headroom for carry and negative exponents
    localparam int RW   = MAN_W + 2;        // rounded significand plus carry
    localparam int LZ_W = $clog2(SW + 1);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EW-1:0]    EXP_MAX  = EW'(EXP_ONES);
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_OUT
    } state_t;

    state_t state_q, state_d;

    // Working registers: operand fields until ALIGN, then big/small operand,
    // then sum and normalised significand share ma_q.
    logic              sa_q, sa_d, sb_q, sb_d;
    logic [EXP_W-1:0]  ea_q, ea_d, eb_q, eb_d;
    logic [SW:0]       ma_q, ma_d;
    logic [SW-1:0]     mb_q, mb_d;
    logic [EW-1:0]     exp_q, exp_d;
    logic              zero_q, zero_d, spec_q, spec_d;
    logic [W-1:0]      spec_res_q, spec_res_d, res_q, res_d;
    logic [3:0]        spec_flags_q, spec_flags_d, flags_q, flags_d;

    // Unpacked inputs and special-case decision
    logic              a_sign, b_sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [EXP_W-1:0]  a_exp, b_exp;
    logic [MAN_W-1:0]  a_frac, b_frac;
    logic [SW-1:0]     a_sig, b_sig;
    logic              spec_hit;
    logic [W-1:0]      spec_res;
    logic [3:0]        spec_flags;

    // Per-stage arithmetic
    logic              swap, big_s, small_s;
    logic [EXP_W-1:0]  big_e, small_e, diff, shamt;
    logic [SW-1:0]     big_m, small_m, aligned;
    logic [2*SW-1:0]   wide;
    logic [SW:0]       sum;
    logic [LZ_W-1:0]   lzc;
    logic [SW-1:0]     norm_shift;
    logic [MAN_W:0]    rnd_mant;
    logic              g_bit, r_bit, s_bit, round_up, inexact;
    logic [RW-1:0]     mant_r;
    logic [EW-1:0]     exp_r;

    // Decode incoming operands; denormals are flushed to signed zero here.
    always_comb begin
        // NOTE: every variable of an always_comb gets a value on every path
        // (defaults first), otherwise synthesis infers a latch.
        a_sign   = in_a[W-1];
        b_sign   = in_b[W-1] ^ in_sub;
        a_exp    = in_a[MAN_W +: EXP_W];
        b_exp    = in_b[MAN_W +: EXP_W];
        a_frac   = in_a[MAN_W-1:0];
        b_frac   = in_b[MAN_W-1:0];
        a_nan    = (a_exp == EXP_ONES) && (a_frac != '0);
        b_nan    = (b_exp == EXP_ONES) && (b_frac != '0);
        a_inf    = (a_exp == EXP_ONES) && (a_frac == '0);
        b_inf    = (b_exp == EXP_ONES) && (b_frac == '0);
        a_zero   = (a_exp == '0);
        b_zero   = (b_exp == '0);
        a_sig    = a_zero ? '0 : {1'b1, a_frac, 3'b000};
        b_sig    = b_zero ? '0 : {1'b1, b_frac, 3'b000};
        spec_hit   = 1'b1;
        spec_res   = '0;
        spec_flags = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign))) begin
            spec_res   = QNAN;
            spec_flags = 4'b1000;
        end else if (a_inf) begin
            spec_res = {a_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            spec_res = {b_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (a_zero && b_zero) begin
            spec_res = {a_sign & b_sign, {(W-1){1'b0}}};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // Arithmetic of every stage, computed from the working registers.
    always_comb begin
        // Alignment: larger magnitude becomes A, smaller is shifted into G/R/S.
        swap    = {eb_q, mb_q} > {ea_q, ma_q[SW-1:0]};
        big_s   = swap ? sb_q : sa_q;
        small_s = swap ? sa_q : sb_q;
        big_e   = swap ? eb_q : ea_q;
        small_e = swap ? ea_q : eb_q;
        big_m   = swap ? mb_q : ma_q[SW-1:0];
        small_m = swap ? ma_q[SW-1:0] : mb_q;
        diff    = big_e - small_e;
        shamt   = (diff > EXP_W'(SW)) ? EXP_W'(SW) : diff;
        wide    = {small_m, {SW{1'b0}}} >> shamt;
        aligned = wide[2*SW-1:SW] | {{(SW-1){1'b0}}, |wide[SW-1:0]};

        // Effective operation; |A| >= |B| so the difference never goes negative.
        sum = (sa_q ^ sb_q) ? ({1'b0, ma_q[SW-1:0]} - {1'b0, mb_q})
                            : ({1'b0, ma_q[SW-1:0]} + {1'b0, mb_q});

        // Leading-zero count: the highest set bit wins as i ascends.
        lzc = LZ_W'(SW);
        for (int i = 0; i < SW; i++) begin
            if (ma_q[i]) lzc = LZ_W'(SW - 1 - i);
        end
        norm_shift = ma_q[SW-1:0] << lzc;

        // Round to nearest, ties to even.
        rnd_mant = ma_q[SW-1:3];
        g_bit    = ma_q[2];
        r_bit    = ma_q[1];
        s_bit    = ma_q[0];
        inexact  = g_bit | r_bit | s_bit;
        round_up = g_bit & (r_bit | s_bit | rnd_mant[0]);
        mant_r   = {1'b0, rnd_mant} + RW'(round_up);
        exp_r    = exp_q + EW'(mant_r[RW-1]);
    end

    // FSM next state: one state per clock, held in OUT until the consumer takes the result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_ALIGN;
            S_ALIGN: state_d = S_ADD;
            S_ADD:   state_d = S_NORM;
            S_NORM:  state_d = S_ROUND;
            S_ROUND: state_d = S_OUT;
            S_OUT:   if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values, selected by the current state.
    always_comb begin
        sa_d = sa_q;  sb_d = sb_q;  ea_d = ea_q;  eb_d = eb_q;
        ma_d = ma_q;  mb_d = mb_q;  exp_d = exp_q;
        zero_d = zero_q;  spec_d = spec_q;
        spec_res_d = spec_res_q;  spec_flags_d = spec_flags_q;
        res_d = res_q;  flags_d = flags_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sa_d = a_sign;  sb_d = b_sign;
                    ea_d = a_exp;   eb_d = b_exp;
                    ma_d = {1'b0, a_sig};
                    mb_d = b_sig;
                    zero_d       = 1'b0;
                    spec_d       = spec_hit;
                    spec_res_d   = spec_res;
                    spec_flags_d = spec_flags;
                end
            end
            S_ALIGN: begin
                sa_d  = big_s;
                sb_d  = small_s;
                ma_d  = {1'b0, big_m};
                mb_d  = aligned;
                exp_d = EW'(big_e);
            end
            S_ADD: ma_d = sum;
            S_NORM: begin
                if (ma_q[SW]) begin
                    ma_d  = {1'b0, ma_q[SW:2], ma_q[1] | ma_q[0]};
                    exp_d = exp_q + EW'(1);
                end else begin
                    zero_d = (ma_q[SW-1:0] == '0);
                    ma_d   = {1'b0, norm_shift};
                    exp_d  = exp_q - EW'(lzc);
                end
            end
            S_ROUND: begin
                if (spec_q) begin
                    res_d   = spec_res_q;
                    flags_d = spec_flags_q;
                end else if (zero_q) begin
                    res_d   = '0;
                    flags_d = '0;
                end else if (exp_q[EW-1] || (exp_q == '0)) begin
                    res_d   = {sa_q, {(W-1){1'b0}}};
                    flags_d = 4'b0011;
                end else if (exp_r >= EXP_MAX) begin
                    res_d   = {sa_q, EXP_ONES, {MAN_W{1'b0}}};
                    flags_d = 4'b0101;
                end else begin
                    res_d   = {sa_q, exp_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
                    flags_d = {3'b000, inexact};
                end
            end
            default: ;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // pre-edge values regardless of statement order.
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Datapath and result registers.
    always_ff @(posedge clk) begin
        // NOTE: the datapath is reset as well as the outputs so a result can
        // never be built from values left over from before reset.
        if (reset) begin
            sa_q <= 1'b0;  sb_q <= 1'b0;  ea_q <= '0;  eb_q <= '0;
            ma_q <= '0;    mb_q <= '0;    exp_q <= '0;
            zero_q <= 1'b0;  spec_q <= 1'b0;
            spec_res_q <= '0;  spec_flags_q <= '0;
            res_q <= '0;  flags_q <= '0;
        end else begin
            sa_q <= sa_d;  sb_q <= sb_d;  ea_q <= ea_d;  eb_q <= eb_d;
            ma_q <= ma_d;  mb_q <= mb_d;  exp_q <= exp_d;
            zero_q <= zero_d;  spec_q <= spec_d;
            spec_res_q <= spec_res_d;  spec_flags_q <= spec_flags_d;
            res_q <= res_d;  flags_q <= flags_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign out_valid  = (state_q == S_OUT);
    assign out_result = res_q;
    assign out_flags  = flags_q;

endmodule
